// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and linear-memory defaults for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_STARVE_LIM = 4;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  // owner doubles as the grant-owner FSM state; valid/oob describe the read in flight
  typedef struct packed {
    owner_e owner;
    logic   valid;
    logic   oob;
  } tag_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating counter with synchronous clear
module starve_counter #(
  parameter int LIM = 4,
  parameter int W   = $clog2(LIM + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(LIM))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core/host single-port memory arbiter with starvation guard and fixed-latency read return
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rdata_vld,
  output logic              err_oob,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rdata_vld,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  logic             core_req;
  logic             core_load;
  logic             core_win;
  logic             host_win;
  logic             oob;
  logic [CNT_W-1:0] starve_cnt;
  tag_t             tag_q;
  logic             ret_core;
  logic             ret_host;
  logic [DATA_W-1:0] core_ret_data;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  assign core_req  = core_re | core_we;
  assign core_load = core_re & ~core_we;
  assign host_win  = host_req & (~core_req | (starve_cnt == CNT_W'(STARVE_LIM)));
  assign core_win  = core_req & ~host_win;
  assign oob       = core_win & (core_addr >= 32'(DEPTH));

  assign core_stall = core_req & host_win;
  assign host_gnt   = host_win;
  assign err_oob    = oob;

  starve_counter #(
    .LIM (STARVE_LIM),
    .W   (CNT_W)
  ) u_starve_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (core_win & host_req),
    .clr   (host_win | ~host_req),
    .cnt   (starve_cnt)
  );

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_win) begin
      mem_re    = core_load & ~oob;
      mem_we    = core_we & ~oob;
      mem_addr  = core_addr[ADDR_W-1:0];
      mem_wdata = core_wdata;
    end else if (host_win) begin
      mem_re    = ~host_we;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Owner moves on every grant and holds when idle; out-of-range loads still
  // carry a valid tag so the core sees a zero-data completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '{owner: OWN_CORE, valid: 1'b0, oob: 1'b0};
    end else if (core_win) begin
      tag_q <= '{owner: OWN_CORE, valid: core_load, oob: oob};
    end else if (host_win) begin
      tag_q <= '{owner: OWN_HOST, valid: ~host_we, oob: 1'b0};
    end else begin
      tag_q.valid <= 1'b0;
      tag_q.oob   <= 1'b0;
    end
  end

  assign ret_core      = tag_q.valid & (tag_q.owner == OWN_CORE);
  assign ret_host      = tag_q.valid & (tag_q.owner == OWN_HOST);
  assign core_ret_data = tag_q.oob ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      if (ret_core) core_rdata_q <= core_ret_data;
      if (ret_host) host_rdata_q <= mem_rdata;
    end
  end

  assign core_rdata_vld = ret_core;
  assign host_rdata_vld = ret_host;
  assign core_rdata     = ret_core ? core_ret_data : core_rdata_q;
  assign host_rdata     = ret_host ? mem_rdata : host_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- ADDR_W, 10, linear-memory address width.
- DATA_W, 32, data width (equal to stack width).
- DEPTH, 1024, linear-memory word count.
- STARVE_LIM, 4, consecutive core wins tolerated while host waits.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- core_re, in, 1, core load request.
- core_we, in, 1, core store request.
- core_addr, in, 32, core byte-free word address (ALU result).
- core_wdata, in, DATA_W, core store data.
- core_stall, out, 1, core request not serviced this cycle.
- core_rdata, out, DATA_W, load data.
- core_rdata_vld, out, 1, load data valid.
- err_oob, out, 1, one-cycle pulse on out-of-range core access.
- host_req, in, 1, host access request.
- host_we, in, 1, host write (0 means read).
- host_addr, in, ADDR_W, host address.
- host_wdata, in, DATA_W, host write data.
- host_gnt, out, 1, host request accepted this cycle.
- host_rdata, out, DATA_W, host read data.
- host_rdata_vld, out, 1, host read data valid.
- mem_re, out, 1, memory read enable.
- mem_we, out, 1, memory write enable.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data (1-cycle latency).

Function
REQ-003 The block SHALL issue at most one memory access per cycle.
REQ-004 A core request SHALL be core_re or core_we; a host request SHALL be host_req.
REQ-005 Arbitration SHALL be core-priority, except that the host wins when starve_cnt equals STARVE_LIM.
REQ-006 starve_cnt SHALL increment when the core wins while host_req is high, clear on any host grant or when host_req is low, and saturate at STARVE_LIM.
REQ-007 The 2-state owner FSM SHALL be: CORE (last grant to core, the reset state) and HOST (last grant to host); the transition SHALL be taken on each grant and the state SHALL hold when idle.
REQ-008 Grant, mem_* and core_stall SHALL be combinational in the cycle of the request; core_stall = core request AND host granted.
REQ-009 A core_addr >= DEPTH SHALL suppress mem_re and mem_we, pulse err_oob the same cycle, and still grant the core.
REQ-010 For an out-of-range load, the block SHALL assert core_rdata_vld the next cycle with data 0.
REQ-011 core_re and core_we high together SHALL be treated as a store; no read data SHALL be returned.
REQ-012 Read return SHALL have fixed latency 1: a registered tag (owner, valid, oob) routes mem_rdata to exactly one *_rdata/*_rdata_vld in the next cycle.
REQ-013 A write SHALL produce no rdata_vld.
REQ-014 core_rdata and host_rdata SHALL hold their last value while the matching vld is low.
REQ-015 mem_addr SHALL be core_addr[ADDR_W-1:0] on a core grant, host_addr on a host grant, and 0 when idle.

Reset
REQ-016 On rst_n low, asynchronously: FSM = CORE, starve_cnt = 0, tag cleared.
REQ-017 On rst_n low, all registered outputs SHALL be 0, and combinational outputs SHALL be 0 given idle inputs.
REQ-018 A read in flight at reset SHALL be dropped, with no vld after release.

Structure
REQ-019 The owner-state encoding and the tag record SHALL reside in the shared package.
REQ-020 The ADDR_W/DATA_W/DEPTH defaults SHALL reside in the shared package, matching the linear-memory settings.
REQ-021 One sub-module SHALL be used: starve_counter (saturating counter with clear).
REQ-022 The memory itself SHALL stay external.

Verification
REQ-023 Core load at addr 5 (mem[5]=0xDEAD), host idle -> mem_re=1 at cycle N; core_rdata=0xDEAD, core_rdata_vld=1 at N+1; core_stall=0.
REQ-024 Host write addr 3 data 0x11, core idle -> host_gnt=1, mem_we=1, mem_addr=3; no vld either side.
REQ-025 Core and host both request continuously, STARVE_LIM=4 -> 4 core grants, 1 host grant with core_stall=1, pattern repeats.
REQ-026 Core load at addr 2000 (DEPTH=1024) -> mem_re=0, err_oob=1 for one cycle; next cycle core_rdata_vld=1, core_rdata=0.
REQ-027 Host read issued, rst_n low in the following cycle -> host_rdata_vld stays 0; all outputs 0; FSM = CORE.
REQ-028 core_re=core_we=1, addr 7, wdata 0x55 -> mem_we=1, mem_re=0; core_rdata_vld=0 in the next cycle.
